// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants and the bit-mixing functions
// used by both the message-schedule unit and the compression round unit.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WIN_N   = 16;
  localparam int unsigned T_W     = 6;

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Round-constant ROM lookup.
  function automatic logic [WORD_W-1:0] k_lookup(input logic [T_W-1:0] idx);
    return K[idx];
  endfunction

  function automatic logic [WORD_W-1:0] ROTR_32(input logic [WORD_W-1:0] x,
                                                input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] SHR(input logic [WORD_W-1:0] x,
                                            input int unsigned n);
    return x >> n;
  endfunction

  // Message-schedule mixers.
  function automatic logic [WORD_W-1:0] sigma0_32(input logic [WORD_W-1:0] x);
    return ROTR_32(x, 7) ^ ROTR_32(x, 18) ^ SHR(x, 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1_32(input logic [WORD_W-1:0] x);
    return ROTR_32(x, 17) ^ ROTR_32(x, 19) ^ SHR(x, 10);
  endfunction

  // Compression-round mixers.
  function automatic logic [WORD_W-1:0] Sigma0_32(input logic [WORD_W-1:0] x);
    return ROTR_32(x, 2) ^ ROTR_32(x, 13) ^ ROTR_32(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] Sigma1_32(input logic [WORD_W-1:0] x);
    return ROTR_32(x, 6) ^ ROTR_32(x, 11) ^ ROTR_32(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] Ch(input logic [WORD_W-1:0] x,
                                           input logic [WORD_W-1:0] y,
                                           input logic [WORD_W-1:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] Maj(input logic [WORD_W-1:0] x,
                                            input logic [WORD_W-1:0] y,
                                            input logic [WORD_W-1:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/xunit_m_if.sv
// Control and data bundle between the Versat datapath and the SHA-256
// message-schedule unit.
interface xunit_m_if #(parameter int unsigned DELAY_W = 7);
  logic               running;
  logic               run;
  logic               done;
  logic [31:0]        in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7;
  logic [31:0]        in8,  in9,  in10, in11, in12, in13, in14, in15;
  logic [31:0]        out0;
  logic [31:0]        out1;
  logic [DELAY_W-1:0] delay0;

  modport master (
    output running, run, delay0,
    output in0, in1, in2,  in3,  in4,  in5,  in6,  in7,
    output in8, in9, in10, in11, in12, in13, in14, in15,
    input  done, out0, out1
  );

  modport slave (
    input  running, run, delay0,
    input  in0, in1, in2,  in3,  in4,  in5,  in6,  in7,
    input  in8, in9, in10, in11, in12, in13, in14, in15,
    output done, out0, out1
  );
endinterface

// File: rtl/xunit_m.sv
// SHA-256 message-schedule unit: loads a 16-word block after a programmable
// delay and streams W_t / K_t for t = 0..63, one pair per running cycle.
module xunit_m
  import sha256_pkg::*;
#(
  parameter int unsigned DELAY_W = 7
) (
  input  logic       clk,
  input  logic       rst,
  xunit_m_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STREAM,
    ST_HOLD
  } state_t;

  localparam logic [T_W-1:0] T_LAST_STEP = T_W'(62);

  state_t              state;
  logic [WORD_W-1:0]   win [WIN_N];
  logic [T_W-1:0]      t;
  logic [DELAY_W-1:0]  delay;
  logic [WORD_W-1:0]   w_q;
  logic [WORD_W-1:0]   k_q;
  logic                done_q;

  logic [WORD_W-1:0]   in_words [WIN_N];
  logic [WORD_W-1:0]   w_new;

  always_comb begin
    in_words[0]  = bus.in0;
    in_words[1]  = bus.in1;
    in_words[2]  = bus.in2;
    in_words[3]  = bus.in3;
    in_words[4]  = bus.in4;
    in_words[5]  = bus.in5;
    in_words[6]  = bus.in6;
    in_words[7]  = bus.in7;
    in_words[8]  = bus.in8;
    in_words[9]  = bus.in9;
    in_words[10] = bus.in10;
    in_words[11] = bus.in11;
    in_words[12] = bus.in12;
    in_words[13] = bus.in13;
    in_words[14] = bus.in14;
    in_words[15] = bus.in15;
  end

  // Next schedule word from the sliding window (win[0] is W_t).
  assign w_new = sigma1_32(win[14]) + win[9] + sigma0_32(win[1]) + win[0];

  // HOLD is entered on the step that presents W63, so done rises together
  // with the last word instead of one cycle after it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      t      <= '0;
      delay  <= '0;
      w_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b1;
      for (int i = 0; i < int'(WIN_N); i++) begin
        win[i] <= '0;
      end
    end else if (bus.run) begin
      delay  <= bus.delay0;
      t      <= '0;
      state  <= ST_WAIT;
      done_q <= 1'b0;
    end else if (bus.running) begin
      case (state)
        ST_WAIT: begin
          if (delay != '0) begin
            delay <= delay - DELAY_W'(1);
          end else begin
            for (int i = 0; i < int'(WIN_N); i++) begin
              win[i] <= in_words[i];
            end
            w_q   <= in_words[0];
            k_q   <= k_lookup(T_W'(0));
            t     <= '0;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          for (int i = 0; i < int'(WIN_N) - 1; i++) begin
            win[i] <= win[i+1];
          end
          win[WIN_N-1] <= w_new;
          w_q          <= win[1];
          k_q          <= k_lookup(t + T_W'(1));
          t            <= t + T_W'(1);
          if (t == T_LAST_STEP) begin
            state  <= ST_HOLD;
            done_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out0 = w_q;
  assign bus.out1 = k_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_xunit_m.sv
// Directed bench for the SHA-256 message-schedule unit with its own
// schedule model and round-constant table.
module tb_xunit_m;

  localparam int unsigned DW = 7;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  xunit_m_if #(.DELAY_W(DW)) bus ();

  xunit_m #(.DELAY_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] msg  [16];
  logic [31:0] wexp [64];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic compute_schedule();
    for (int i = 0; i < 16; i++) wexp[i] = msg[i];
    for (int i = 16; i < 64; i++)
      wexp[i] = s1(wexp[i-2]) + wexp[i-7] + s0(wexp[i-15]) + wexp[i-16];
  endtask

  task automatic drive_words(input logic [31:0] v [16]);
    bus.in0  = v[0];  bus.in1  = v[1];  bus.in2  = v[2];  bus.in3  = v[3];
    bus.in4  = v[4];  bus.in5  = v[5];  bus.in6  = v[6];  bus.in7  = v[7];
    bus.in8  = v[8];  bus.in9  = v[9];  bus.in10 = v[10]; bus.in11 = v[11];
    bus.in12 = v[12]; bus.in13 = v[13]; bus.in14 = v[14]; bus.in15 = v[15];
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Walks W0..W63 starting in the cycle where W0 is expected; ends at L+64.
  task automatic check_stream(input string tag);
    logic exp_done;
    for (int t = 0; t < 64; t++) begin
      exp_done = (t == 63);
      checks++;
      if (bus.out0 !== wexp[t]) begin
        errors++;
        $display("FAIL %s W[%0d]: got %h expected %h", tag, t, bus.out0, wexp[t]);
      end
      checks++;
      if (bus.out1 !== kt[t]) begin
        errors++;
        $display("FAIL %s K[%0d]: got %h expected %h", tag, t, bus.out1, kt[t]);
      end
      checks++;
      if (bus.done !== exp_done) begin
        errors++;
        $display("FAIL %s done@t%0d: got %b expected %b", tag, t, bus.done, exp_done);
      end
      if (t < 63) tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] z [16];
    for (int i = 0; i < 16; i++) z[i] = '0;
    drive_words(z);
    rst = 1'b1; bus.running = 1'b0; bus.run = 1'b0; bus.delay0 = '0;
    repeat (3) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.out0 !== 32'h0 || bus.out1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_values: done=%b out0=%h out1=%h expected 1/0/0", bus.done, bus.out0, bus.out1);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.running = c[0];
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.out0 !== 32'h0 || bus.out1 !== 32'h0) begin
        errors++;
        $display("FAIL idle_running_toggle c%0d: done=%b out0=%h out1=%h expected 1/0/0", c, bus.done, bus.out0, bus.out1);
      end
    end
  endtask

  task automatic test_abc();
    logic [31:0] junk [16];
    for (int i = 0; i < 16; i++) begin
      msg[i] = '0;
      junk[i] = 32'hdeadbeef ^ 32'(i);
    end
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    compute_schedule();
    drive_words(msg);
    bus.delay0 = '0; bus.running = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abc_done_fall: got %b expected 0", bus.done);
    end
    tick();
    // Inputs are sampled only at load; scramble them now.
    drive_words(junk);
    checks++;
    if (bus.out0 !== 32'h61626380 || bus.out1 !== 32'h428a2f98) begin
      errors++;
      $display("FAIL abc_t0: out0=%h out1=%h expected 61626380/428a2f98", bus.out0, bus.out1);
    end
    checks++;
    if (wexp[16] !== 32'h61626380 || wexp[17] !== 32'h000f0000) begin
      errors++;
      $display("FAIL abc_model_w16_w17: got %h %h expected 61626380 000f0000", wexp[16], wexp[17]);
    end
    check_stream("abc");
    checks++;
    if (bus.out1 !== 32'hc67178f2) begin
      errors++;
      $display("FAIL abc_k63: got %h expected c67178f2", bus.out1);
    end
    repeat (3) tick();
    checks++;
    if (bus.out0 !== wexp[63] || bus.out1 !== 32'hc67178f2 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL abc_hold: out0=%h out1=%h done=%b expected %h/c67178f2/1", bus.out0, bus.out1, bus.done, wexp[63]);
    end
  endtask

  task automatic test_delay();
    logic [31:0] held0, held1;
    held0 = bus.out0;
    held1 = bus.out1;
    for (int i = 0; i < 16; i++) msg[i] = 32'h9e3779b9 * 32'(i + 1);
    compute_schedule();
    drive_words(msg);
    bus.delay0 = DW'(5); bus.running = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.out0 !== held0 || bus.out1 !== held1) begin
        errors++;
        $display("FAIL delay_wait R+%0d: done=%b out0=%h out1=%h expected 0/%h/%h", k, bus.done, bus.out0, bus.out1, held0, held1);
      end
      tick();
    end
    check_stream("delay5");
  endtask

  task automatic test_stall();
    int idx, runs, cyc;
    logic r, exp_done;
    for (int i = 0; i < 16; i++) msg[i] = 32'hffffffff - 32'(i) * 32'h01020304;
    compute_schedule();
    drive_words(msg);
    bus.delay0 = DW'(2); bus.running = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (3) tick();
    idx = 0; runs = 1; cyc = 0;
    checks++;
    if (bus.out0 !== wexp[0]) begin
      errors++;
      $display("FAIL stall_w0: got %h expected %h", bus.out0, wexp[0]);
    end
    while (idx < 63 && cyc < 600) begin
      r = (cyc % 4 == 1) ? 1'b0 : ($urandom_range(0, 2) != 0);
      bus.running = r;
      tick();
      cyc++;
      if (r) begin
        idx++;
        runs++;
      end
      exp_done = (idx == 63);
      checks++;
      if (bus.out0 !== wexp[idx] || bus.out1 !== kt[idx] || bus.done !== exp_done) begin
        errors++;
        $display("FAIL stall idx%0d cyc%0d: out0=%h out1=%h done=%b expected %h/%h/%b", idx, cyc, bus.out0, bus.out1, bus.done, wexp[idx], kt[idx], exp_done);
      end
    end
    bus.running = 1'b1;
    checks++;
    if (idx != 63 || runs != 64) begin
      errors++;
      $display("FAIL stall_run_count: idx=%0d runs=%0d expected 63/64", idx, runs);
    end
  endtask

  task automatic test_restart();
    logic [31:0] held0, held1;
    for (int i = 0; i < 16; i++) msg[i] = '0;
    msg[0] = 32'h61626380;
    msg[15] = 32'h00000018;
    compute_schedule();
    drive_words(msg);
    bus.delay0 = '0; bus.running = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    repeat (30) tick();
    held0 = wexp[30];
    held1 = kt[30];
    checks++;
    if (bus.out0 !== held0 || bus.out1 !== held1) begin
      errors++;
      $display("FAIL restart_t30: out0=%h out1=%h expected %h/%h", bus.out0, bus.out1, held0, held1);
    end
    for (int i = 0; i < 16; i++) msg[i] = 32'h80000000 >> i;
    compute_schedule();
    drive_words(msg);
    bus.delay0 = DW'(3); bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.done !== 1'b0 || bus.out0 !== held0 || bus.out1 !== held1) begin
        errors++;
        $display("FAIL restart_wait R+%0d: done=%b out0=%h out1=%h expected 0/%h/%h", k, bus.done, bus.out0, bus.out1, held0, held1);
      end
      tick();
    end
    check_stream("restart");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) msg[i] = 32'hffffffff;
    compute_schedule();
    drive_words(msg);
    bus.delay0 = '0; bus.running = 1'b1; bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    repeat (40) tick();
    checks++;
    if (bus.out0 !== wexp[40] || bus.out1 !== kt[40]) begin
      errors++;
      $display("FAIL rstmid_t40: out0=%h out1=%h expected %h/%h", bus.out0, bus.out1, wexp[40], kt[40]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out0 !== 32'h0 || bus.out1 !== 32'h0 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: out0=%h out1=%h done=%b expected 0/0/1", bus.out0, bus.out1, bus.done);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (bus.out0 !== 32'h0 || bus.out1 !== 32'h0 || bus.done !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet c%0d: out0=%h out1=%h done=%b expected 0/0/1", c, bus.out0, bus.out1, bus.done);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.running = 1'b0;
    bus.run = 1'b0;
    bus.delay0 = '0;
    @(negedge clk);
    test_reset();
    test_abc();
    test_delay();
    test_stall();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
